// File: rtl/prescaled_mod_counter.sv
// Prescaled up/down modulo counter with runtime terminal value.
// A ce_i prescaler turns every PRESCALE-th qualifying ce_i cycle into a count
// step. The counter wraps or saturates within 0..max_i. It has a synchronous
// load, a one-cycle terminal-count pulse and a nonzero flag.
module prescaled_mod_counter #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             ce_i,
    input  logic             dir_i,
    input  logic             mode_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic [WIDTH-1:0] max_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             active_o
);

    // The prescaler needs at least one bit even when PRESCALE is 1, so the
    // "last phase" compare degenerates to a constant true.
    localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

    logic [PSC_W-1:0] psc;
    logic             step;
    logic [WIDTH-1:0] count_inc;
    logic [WIDTH-1:0] count_dec;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] step_count;
    logic             step_tc;

    assign step         = ce_i && (psc == PSC_LAST);
    assign count_inc    = count_o + WIDTH'(1);
    assign count_dec    = count_o - WIDTH'(1);
    assign load_clamped = (load_val_i > max_i) ? max_i : load_val_i;
    assign active_o     = (count_o != '0);

    // Next count and pulse for a step, chosen by direction and wrap/saturate mode.
    always_comb begin
        step_count = count_o;
        step_tc    = 1'b0;
        case ({dir_i, mode_i})
            2'b00: begin
                if (count_o >= max_i) begin
                    step_count = '0;
                    step_tc    = 1'b1;
                end else begin
                    step_count = count_inc;
                end
            end
            2'b01: begin
                if (count_o >= max_i) begin
                    step_count = max_i;
                end else begin
                    step_count = count_inc;
                    step_tc    = (count_inc == max_i);
                end
            end
            2'b10: begin
                if (count_o == '0) begin
                    step_count = max_i;
                    step_tc    = 1'b1;
                end else begin
                    step_count = count_dec;
                end
            end
            default: begin
                if (count_o != '0) begin
                    step_count = count_dec;
                    step_tc    = (count_o == WIDTH'(1));
                end
            end
        endcase
    end

    // Prescaler phase: cleared by reset, load or a step; advances on other ce_i cycles.
    always_ff @(posedge clk_i) begin
        if (reset_i || load_i) begin
            psc <= '0;
        end else if (step) begin
            psc <= '0;
        end else if (ce_i) begin
            psc <= psc + PSC_W'(1);
        end
    end

    // Count register and terminal-count pulse, with priority reset > load > step > hold.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_o <= '0;
            tc_o    <= 1'b0;
        end else if (load_i) begin
            count_o <= load_clamped;
            tc_o    <= 1'b0;
        end else if (step) begin
            count_o <= step_count;
            tc_o    <= step_tc;
        end else begin
            tc_o    <= 1'b0;
        end
    end

endmodule
